video_timing: RTL
=================

VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- H_BORDER, 64, left border before the 512-pixel active window

REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
- gpu_clk, in, 1, sole clock (pixel clock or integer multiple)
- rst, in, 1, synchronous active-high reset
- pix_en_i, in, 1, pixel advance enable
- hsync_o, out, 1, horizontal sync, active low
- vsync_o, out, 1, vertical sync, active low
- display_x_o, out, 8, native column 0..255, feeds text/sprite/background layers
- display_y_o, out, 8, native row 0..239
- display_active_o, out, 1, position inside the 512x480 active window
- vblank_o, out, 1, level, high during vertical blanking
- line_start_o, out, 1, one-clock strobe at h=0
- vblank_start_o, out, 1, one-clock strobe at (h=0, v=V_VISIBLE), CPU interrupt source
- frame_start_o, out, 1, one-clock strobe at (0,0)

Function
REQ-003 SHALL keep h counter (0..H_TOTAL-1, H_TOTAL=800) and v counter (0..V_TOTAL-1, V_TOTAL=525); widths SHALL be the minimum that holds the total.
REQ-004 SHALL advance h by 1 on each gpu_clk edge with pix_en_i=1; with pix_en_i=0, counters and all level outputs SHALL hold.
REQ-005 SHALL wrap h from H_TOTAL-1 to 0 and simultaneously increment v; v SHALL wrap from V_TOTAL-1 to 0 on the same edge that h wraps.
REQ-006 SHALL register all outputs; in every clock, outputs SHALL describe the currently held position (h,v), with no combinational path from pix_en_i.
REQ-007 SHALL drive hsync_o=0 iff H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC (656..751 by default).
REQ-008 SHALL drive vsync_o=0 iff V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC (490..491 by default).
REQ-009 SHALL drive display_active_o=1 iff H_BORDER <= h < H_BORDER+512 and v < V_VISIBLE.
REQ-010 SHALL drive display_x_o=(h-H_BORDER)>>1 when active, else 0; display_y_o=v>>1 when v<V_VISIBLE, else 0.
REQ-011 SHALL drive vblank_o=1 iff v >= V_VISIBLE.
REQ-012 SHALL raise each strobe for exactly one gpu_clk cycle: the first cycle its position is presented. A strobe SHALL NOT repeat while pix_en_i=0 holds that position.
REQ-013 SHALL raise line_start_o, frame_start_o and vblank_start_o in the same cycle when their positions coincide (frame_start_o with line_start_o at (0,0)).

Reset
REQ-014 SHALL, while rst=1, force h=0, v=0, hsync_o=1, vsync_o=1, display_x_o=0, display_y_o=0, display_active_o=0, vblank_o=0, and all strobes 0.
REQ-015 SHALL, in the first cycle after rst falls, present (0,0) and assert line_start_o=1 and frame_start_o=1 for one cycle; rst SHALL take priority over pix_en_i.
REQ-016 SHALL, on reset asserted mid-frame, abandon the current position with no partial strobes, then restart per REQ-015.

Verification
REQ-017 Reset, then pix_en_i=1 for 1600 clocks:
- hsync_o low exactly 96 cycles per line, at h=656..751
- line_start_o high at clocks 0 and 800 only
REQ-018 Active window, line v=0:
- h=63: active=0, x=0
- h=64: active=1, x=0
- h=65: x=0
- h=66: x=1
- h=575: x=255
- h=576: active=0, x=0
REQ-019 Full frame of 420000 enabled clocks:
- v=479: display_y_o=239
- v=480: vblank_o rises and vblank_start_o pulses once
- vsync_o low for exactly 1600 clocks, at v=490..491
REQ-020 Wrap: at (799,524), the next enabled clock presents (0,0) with line_start_o=frame_start_o=1 and vblank_o=0.
REQ-021 pix_en_i alternating 1,0: position advances every second clock, and every strobe stays exactly one clock wide.
REQ-022 rst pulsed for 1 clock at (300,100): next clock shows REQ-014 values, then (0,0) with frame_start_o=1.

Source files
------------

// File: rtl/video_timing.sv
// video_timing: raster position generator for a 640x480 style display that
// hosts a 512x480 active window, scaled 2x from a native 256x240 frame.
//
// Ports:
//   gpu_clk          - sole clock (pixel clock or integer multiple)
//   rst              - synchronous active-high reset
//   pix_en_i         - pixel advance enable
//   hsync_o          - horizontal sync, active low
//   vsync_o          - vertical sync, active low
//   display_x_o      - native column 0..255 inside the active window, else 0
//   display_y_o      - native row 0..239 on visible lines, else 0
//   display_active_o - position lies inside the 512x480 active window
//   vblank_o         - high on lines v >= V_VISIBLE
//   line_start_o     - one-clock strobe when h=0 is first presented
//   vblank_start_o   - one-clock strobe at (0, V_VISIBLE)
//   frame_start_o    - one-clock strobe at (0, 0)
//
// Every output is a register describing the position held in h_q/v_q.
// The next position and its decode are computed combinationally and loaded
// together, so outputs and counters always agree.
module video_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int H_BORDER  = 64
) (
  input  logic       gpu_clk,
  input  logic       rst,
  input  logic       pix_en_i,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic [7:0] display_x_o,
  output logic [7:0] display_y_o,
  output logic       display_active_o,
  output logic       vblank_o,
  output logic       line_start_o,
  output logic       vblank_start_o,
  output logic       frame_start_o
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_BORDER);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_BORDER + 512);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS      = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [HW-1:0] h_q, h_n;
  logic [VW-1:0] v_q, v_n;
  // Set while in reset; the first clock after release presents (0,0) with
  // its strobes regardless of pix_en_i.
  logic          restart_q;
  // A new position is loaded this clock (fresh position => strobes allowed).
  logic          present;

  logic          hsync_d, vsync_d, active_d, vblank_d, v_vis_d;
  logic [7:0]    x_d, y_d;

  always_comb begin
    h_n     = h_q;
    v_n     = v_q;
    present = 1'b0;
    if (restart_q) begin
      h_n     = '0;
      v_n     = '0;
      present = 1'b1;
    end else if (pix_en_i) begin
      present = 1'b1;
      if (h_q == H_LAST) begin
        h_n = '0;
        v_n = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_n = h_q + 1'b1;
      end
    end
  end

  always_comb begin
    hsync_d  = !((h_n >= H_SYNC_BEG) && (h_n < H_SYNC_END));
    vsync_d  = !((v_n >= V_SYNC_BEG) && (v_n < V_SYNC_END));
    v_vis_d  = (v_n < V_VIS);
    vblank_d = !v_vis_d;
    active_d = (h_n >= H_ACT_BEG) && (h_n < H_ACT_END) && v_vis_d;
    // Each native pixel/line spans two raster pixels/lines.
    x_d      = active_d ? 8'((h_n - H_ACT_BEG) >> 1) : 8'd0;
    y_d      = v_vis_d ? 8'(v_n >> 1) : 8'd0;
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      h_q              <= '0;
      v_q              <= '0;
      restart_q        <= 1'b1;
      hsync_o          <= 1'b1;
      vsync_o          <= 1'b1;
      display_x_o      <= 8'd0;
      display_y_o      <= 8'd0;
      display_active_o <= 1'b0;
      vblank_o         <= 1'b0;
      line_start_o     <= 1'b0;
      vblank_start_o   <= 1'b0;
      frame_start_o    <= 1'b0;
    end else begin
      restart_q      <= 1'b0;
      line_start_o   <= 1'b0;
      vblank_start_o <= 1'b0;
      frame_start_o  <= 1'b0;
      if (present) begin
        h_q              <= h_n;
        v_q              <= v_n;
        hsync_o          <= hsync_d;
        vsync_o          <= vsync_d;
        display_x_o      <= x_d;
        display_y_o      <= y_d;
        display_active_o <= active_d;
        vblank_o         <= vblank_d;
        line_start_o     <= (h_n == '0);
        vblank_start_o   <= (h_n == '0) && (v_n == V_VIS);
        frame_start_o    <= (h_n == '0) && (v_n == '0);
      end
    end
  end

endmodule
